bit_selection_cmd_sched: RTL
============================

Name: bit_selection_cmd_sched

Overview:
Sequencer that drives the en/cmd inputs of one 8-to-4 bit-selection stage (1-cycle latency, cmd[2] = shift enable, cmd[1:0] = offset) across a job of N input beats.
- Per beat, the offset advances by a programmed stride (mod 4), with upstream valid/ready flow control.
- Counts returned datapath valids and pulses done when the job has fully drained.
- Sits between the NoC configuration/controller logic and the selection datapath.

Parameters:
DATA_WIDTH, 8, datapath input width; only 8 supported.
COMMAND_WIDTH, 3, datapath command width (1 shift bit + OFFSET_WIDTH).
OFFSET_WIDTH, 2, COMMAND_WIDTH-1; offset field width.
COUNT_WIDTH, 8, width of the job-length and beat counters.

Ports:
clk  in  1  clock, all logic on posedge.
rst  in  1  synchronous, active-low reset.
i_start  in  1  job start pulse; honoured only in IDLE.
i_cfg_shift  in  1  shift enable for the job (becomes cmd[2]).
i_cfg_base  in  OFFSET_WIDTH  first-beat offset.
i_cfg_stride  in  OFFSET_WIDTH  per-beat offset increment.
i_cfg_len  in  COUNT_WIDTH  beats in the job.
i_valid  in  1  upstream beat valid.
o_ready  out  1  scheduler accepts a beat (beat is issued when i_valid & o_ready).
o_sel_en  out  1  to datapath i_en.
o_sel_cmd  out  COMMAND_WIDTH  to datapath i_cmd.
i_sel_valid  in  1  datapath o_valid return.
o_busy  out  1  high in RUN or DRAIN.
o_done  out  1  one-cycle pulse at job completion.
o_err  out  1  sticky: a return arrived with nothing outstanding.

Behaviour:
- Reset (rst==0 at posedge):
  - State goes to IDLE; all counters clear.
  - o_ready, o_sel_en, o_sel_cmd, o_busy, o_done and o_err all go to 0.
  - Reset mid-job aborts it; no done pulse is produced.
- States: IDLE, RUN, DRAIN. Outputs are registered.
- IDLE:
  - o_ready=0, o_sel_en=0.
  - On i_start: latch shift/base/stride/len; clear issued, returned and o_err.
  - len!=0: go to RUN with offset=base. len==0: no issue, o_done pulses the next cycle, stay IDLE.
- RUN:
  - o_ready=1, o_sel_en=1, o_sel_cmd={shift, offset}.
  - On each handshake: issued++ and offset <= (offset+stride) mod 2^OFFSET_WIDTH, wrapping silently.
  - The command on o_sel_cmd during the handshake cycle is the one the datapath samples for that beat.
  - When the handshake makes issued==len: o_ready and o_sel_en drop to 0 the next cycle, and state goes to DRAIN.
  - No i_valid means no advance: offset and counters hold.
- DRAIN:
  - o_ready=0, o_sel_en=0.
  - o_sel_cmd[2] stays at the job's shift value, because the datapath output mux is combinational on cmd[2].
  - o_sel_cmd[1:0] holds the last issued offset.
- Return counting:
  - Active in RUN and DRAIN: returned++ on each i_sel_valid.
  - A last issue and a return in the same cycle are both counted.
  - When returned==len: o_done=1 for exactly one cycle, o_busy=0, state goes to IDLE, and o_sel_cmd clears to 0.
- Error: i_sel_valid while returned>=issued, or while in IDLE, sets o_err. The spurious return is not counted; o_err clears only on the next accepted i_start or on reset.
- Ignored inputs: i_start is ignored in RUN and DRAIN. Config inputs are sampled only at an accepted start.
- Latency:
  - Start to first o_ready: 1 cycle.
  - Last handshake to o_done: 2 cycles with a 1-cycle datapath, i.e. the last return plus 1 cycle.
- Arithmetic: counters are COUNT_WIDTH bits; max job is 2^COUNT_WIDTH-1 beats; no counter overflow is possible.

Decomposition:
- Shared package bit_sel_pkg holds:
  - the state encoding (IDLE=0, RUN=1, DRAIN=2);
  - CMD_SHIFT_BIT = COMMAND_WIDTH-1;
  - OFFSET_WIDTH;
  - the supported DATA_WIDTH constant (8).
- One sub-module, bit_sel_offset_gen: holds the offset register with load-base/advance-by-stride/hold control and mod-2^OFFSET_WIDTH wrap. The FSM and counters stay in the top.

Test Plan:
1. Basic run: start with shift=1, base=0, stride=1, len=6, i_valid held high → o_sel_cmd over 6 handshakes = 4,5,6,7,4,5; o_sel_cmd holds 5 during DRAIN; 6 returns; o_done pulses once, 2 cycles after the last handshake.
2. Pass-through with stride wrap: shift=0, base=3, stride=2, len=3 → cmds 3,1,3; cmd[2]=0 throughout the job.
3. Backpressure gaps: len=4 with i_valid pattern 1,0,0,1,1,0,1 → offset advances only on the 4 high cycles; issued=4, then DRAIN, then done.
4. Zero length and busy start: start with len=0 → o_ready never rises, o_done pulses the next cycle. Then start len=2, and pulse i_start again during RUN with base=2 → the second start is ignored and the cmd sequence is unchanged.
5. Reset mid-job: rst=0 after 2 of 5 beats → the next cycle o_busy=0, o_sel_en=0, o_sel_cmd=0 and no o_done. A fresh start then runs all 5 beats.
6. Spurious return: i_sel_valid pulsed while IDLE → o_err=1 and stays high through the next IDLE; the next accepted start clears it and the job completes normally.

Source files
------------

// File: rtl/bit_sel_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bit_sel_pkg
//  Purpose  : Shared constants and state encoding for the bit-selection
//             command scheduler and its offset generator.
//  Contents : DATA_WIDTH_SUPPORTED, COMMAND_WIDTH, OFFSET_WIDTH,
//             CMD_SHIFT_BIT, sched_state_e (IDLE=0, RUN=1, DRAIN=2)
//  Revision : 1.0 - initial release
// ============================================================================
package bit_sel_pkg;

    // The selection datapath this scheduler drives is fixed at 8 input bits.
    localparam int DATA_WIDTH_SUPPORTED = 8;
    localparam int OFFSET_WIDTH         = 2;
    localparam int COMMAND_WIDTH        = OFFSET_WIDTH + 1;
    // cmd[MSB] selects shift vs. pass-through in the datapath output mux.
    localparam int CMD_SHIFT_BIT        = COMMAND_WIDTH - 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } sched_state_e;

endpackage : bit_sel_pkg
`default_nettype wire

// File: rtl/bit_selection_cmd_sched_if.sv
`default_nettype none
// ============================================================================
//  Module   : bit_selection_cmd_sched_if
//  Purpose  : Beat handshake and datapath command/return bundle of the
//             bit-selection command scheduler. Signal names are seen from
//             the scheduler (i_ = into scheduler, o_ = out of scheduler).
//  Signals  : i_valid     upstream beat valid
//             o_ready     scheduler accepts a beat
//             o_sel_en    datapath enable
//             o_sel_cmd   datapath command {shift, offset}
//             i_sel_valid datapath output-valid return
//  Modports : master - the scheduler; slave - upstream source + datapath
//  Revision : 1.0 - initial release
// ============================================================================
interface bit_selection_cmd_sched_if #(
    parameter int COMMAND_WIDTH = 3
);
    logic                     i_valid;
    logic                     o_ready;
    logic                     o_sel_en;
    logic [COMMAND_WIDTH-1:0] o_sel_cmd;
    logic                     i_sel_valid;

    modport master (
        input  i_valid,
        input  i_sel_valid,
        output o_ready,
        output o_sel_en,
        output o_sel_cmd
    );

    modport slave (
        output i_valid,
        output i_sel_valid,
        input  o_ready,
        input  o_sel_en,
        input  o_sel_cmd
    );
endinterface : bit_selection_cmd_sched_if
`default_nettype wire

// File: rtl/bit_sel_offset_gen.sv
`default_nettype none
// ============================================================================
//  Module   : bit_sel_offset_gen
//  Purpose  : Offset register for the selection command. Loads the job base,
//             advances by the stride (wrapping modulo 2^OFFSET_WIDTH) or holds.
//  Ports    : clk, rst (sync, active-low)
//             i_clear   force offset to 0 (job end)
//             i_load    load i_base (job start)
//             i_advance add i_stride
//             o_offset  current offset
//  Revision : 1.0 - initial release
// ============================================================================
module bit_sel_offset_gen
    import bit_sel_pkg::*;
#(
    parameter int OFFSET_WIDTH = 2
) (
    input  wire logic                    clk,
    input  wire logic                    rst,
    input  wire logic                    i_clear,
    input  wire logic                    i_load,
    input  wire logic [OFFSET_WIDTH-1:0] i_base,
    input  wire logic                    i_advance,
    input  wire logic [OFFSET_WIDTH-1:0] i_stride,
    output logic      [OFFSET_WIDTH-1:0] o_offset
);

    logic [OFFSET_WIDTH-1:0] r_offset;

    // Sum is truncated to OFFSET_WIDTH bits, which is the modulo wrap.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_offset <= '0;
        end else if (i_clear) begin
            r_offset <= '0;
        end else if (i_load) begin
            r_offset <= i_base;
        end else if (i_advance) begin
            r_offset <= r_offset + i_stride;
        end
    end

    assign o_offset = r_offset;

endmodule : bit_sel_offset_gen
`default_nettype wire

// File: rtl/bit_selection_cmd_sched.sv
`default_nettype none
// ============================================================================
//  Module   : bit_selection_cmd_sched
//  Purpose  : Sequences en/cmd of one 8-to-4 bit-selection stage over a job
//             of i_cfg_len beats, counts datapath returns and pulses o_done
//             once the job has drained.
//  Ports    : clk, rst (sync, active-low)
//             i_start, i_cfg_shift/base/stride/len   job start + config
//             bus (master)  beat handshake, datapath en/cmd, return valid
//             o_busy  RUN or DRAIN;  o_done  completion pulse
//             o_err   sticky spurious-return flag
//  Revision : 1.0 - initial release
// ============================================================================
module bit_selection_cmd_sched
    import bit_sel_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int COMMAND_WIDTH = 3,
    parameter int OFFSET_WIDTH  = 2,
    parameter int COUNT_WIDTH   = 8
) (
    input  wire logic                    clk,
    input  wire logic                    rst,
    input  wire logic                    i_start,
    input  wire logic                    i_cfg_shift,
    input  wire logic [OFFSET_WIDTH-1:0] i_cfg_base,
    input  wire logic [OFFSET_WIDTH-1:0] i_cfg_stride,
    input  wire logic [COUNT_WIDTH-1:0]  i_cfg_len,
    bit_selection_cmd_sched_if.master    bus,
    output logic                         o_busy,
    output logic                         o_done,
    output logic                         o_err
);

    generate
        if (DATA_WIDTH != DATA_WIDTH_SUPPORTED || COMMAND_WIDTH != OFFSET_WIDTH + 1) begin : g_param_check
            $error("bit_selection_cmd_sched: unsupported DATA_WIDTH/COMMAND_WIDTH");
        end
    endgenerate

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    sched_state_e            r_state,    w_state_nxt;
    logic [COUNT_WIDTH-1:0]  r_issued,   w_issued_nxt;
    logic [COUNT_WIDTH-1:0]  r_returned, w_returned_nxt;
    logic [COUNT_WIDTH-1:0]  r_len,      w_len_nxt;
    logic [OFFSET_WIDTH-1:0] r_stride,   w_stride_nxt;
    logic                    r_shift,    w_shift_nxt;
    logic                    r_ready,    w_ready_nxt;
    logic                    r_sel_en,   w_sel_en_nxt;
    logic                    r_busy,     w_busy_nxt;
    logic                    r_done,     w_done_nxt;
    logic                    r_err,      w_err_nxt;

    logic                    w_off_clear;
    logic                    w_off_load;
    logic                    w_off_adv;
    logic [OFFSET_WIDTH-1:0] w_offset;

    logic w_hs;
    logic w_start;
    logic w_ret_ok;
    logic w_last_issue;
    logic w_last_return;

    assign w_hs          = bus.i_valid & r_ready;
    assign w_start       = i_start & (r_state == ST_IDLE);
    // A return is legitimate only while a job is active and something is in
    // flight; the issue happening in this same cycle cannot yet have a return.
    assign w_ret_ok      = bus.i_sel_valid & (r_state != ST_IDLE) & (r_returned < r_issued);
    assign w_last_issue  = w_hs & ((r_issued + COUNT_WIDTH'(1)) == r_len);
    assign w_last_return = w_ret_ok & ((r_returned + COUNT_WIDTH'(1)) == r_len);

    always_comb begin
        w_state_nxt    = r_state;
        w_issued_nxt   = r_issued;
        w_returned_nxt = r_returned;
        w_len_nxt      = r_len;
        w_stride_nxt   = r_stride;
        w_shift_nxt    = r_shift;
        w_done_nxt     = 1'b0;
        w_err_nxt      = r_err;
        w_off_clear    = 1'b0;
        w_off_load     = 1'b0;
        w_off_adv      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_len_nxt      = i_cfg_len;
                    w_stride_nxt   = i_cfg_stride;
                    w_issued_nxt   = '0;
                    w_returned_nxt = '0;
                    w_err_nxt      = 1'b0;
                    if (i_cfg_len != '0) begin
                        w_state_nxt = ST_RUN;
                        w_shift_nxt = i_cfg_shift;
                        w_off_load  = 1'b1;
                    end else begin
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (w_hs) begin
                    w_issued_nxt = r_issued + COUNT_WIDTH'(1);
                    // Last offset is held through DRAIN rather than advanced.
                    if (w_last_issue) begin
                        w_state_nxt = ST_DRAIN;
                    end else begin
                        w_off_adv   = 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (w_ret_ok) begin
            w_returned_nxt = r_returned + COUNT_WIDTH'(1);
            if (w_last_return) begin
                w_state_nxt = ST_IDLE;
                w_done_nxt  = 1'b1;
                w_shift_nxt = 1'b0;
                w_off_clear = 1'b1;
            end
        end

        if (bus.i_sel_valid && !w_ret_ok) begin
            w_err_nxt = 1'b1;
        end

        w_ready_nxt  = (w_state_nxt == ST_RUN);
        w_sel_en_nxt = (w_state_nxt == ST_RUN);
        w_busy_nxt   = (w_state_nxt != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_issued   <= '0;
            r_returned <= '0;
            r_len      <= '0;
            r_stride   <= '0;
            r_shift    <= 1'b0;
            r_ready    <= 1'b0;
            r_sel_en   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_issued   <= w_issued_nxt;
            r_returned <= w_returned_nxt;
            r_len      <= w_len_nxt;
            r_stride   <= w_stride_nxt;
            r_shift    <= w_shift_nxt;
            r_ready    <= w_ready_nxt;
            r_sel_en   <= w_sel_en_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_err      <= w_err_nxt;
        end
    end

    bit_sel_offset_gen #(
        .OFFSET_WIDTH (OFFSET_WIDTH)
    ) u_offset_gen (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (w_off_clear),
        .i_load    (w_off_load),
        .i_base    (i_cfg_base),
        .i_advance (w_off_adv),
        .i_stride  (r_stride),
        .o_offset  (w_offset)
    );

    // Shift bit is a job-long register: the datapath output mux reads it
    // combinationally, so it must stay valid until the last return.
    assign bus.o_ready   = r_ready;
    assign bus.o_sel_en  = r_sel_en;
    assign bus.o_sel_cmd = {r_shift, w_offset};
    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_err         = r_err;

endmodule : bit_selection_cmd_sched
`default_nettype wire
